// File: rtl/text_console_writer_pkg.sv
// Shared display widths, ctrl_reg layout, control codes and console states.
package text_console_writer_pkg;

  localparam int DP_X_ADDR_WIDTH = 7;
  localparam int DP_Y_ADDR_WIDTH = 5;
  localparam int DP_REG_WIDTH    = 32;

  localparam int CUR_X_LSB = 0;
  localparam int CUR_X_MSB = 7;
  localparam int CUR_Y_LSB = 8;
  localparam int CUR_Y_MSB = 12;

  localparam int TXT_COLS = 80;
  localparam int TXT_ROWS = 30;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_FF  = 8'h0C;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLR,
    ST_SC_RD,
    ST_SC_WR
  } state_t;

endpackage

// File: rtl/text_console_writer_sweep_counter.sv
// Row-major (x, y) walker shared by the clear and scroll sweeps.
module console_sweep_counter
  import text_console_writer_pkg::*;
#(
  parameter int COLS = TXT_COLS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [DP_X_ADDR_WIDTH-1:0] start_x,
  input  logic [DP_Y_ADDR_WIDTH-1:0] start_y,
  input  logic [DP_Y_ADDR_WIDTH-1:0] end_row,
  input  logic                       step,
  output logic [DP_X_ADDR_WIDTH-1:0] x,
  output logic [DP_Y_ADDR_WIDTH-1:0] y,
  output logic                       done
);

  localparam logic [DP_X_ADDR_WIDTH-1:0] X_LAST =
    DP_X_ADDR_WIDTH'(COLS - 1);

  logic [DP_Y_ADDR_WIDTH-1:0] end_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      end_q <= '0;
    end else if (load) begin
      x     <= start_x;
      y     <= start_y;
      end_q <= end_row;
    end else if (step) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign done = (x == X_LAST) && (y == end_q);

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console writer for the 80x30 text buffer.
// Optional scroll at the bottom row: define CONSOLE_SCROLL_EN.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int COLS = TXT_COLS,
  parameter int ROWS = TXT_ROWS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       char_valid,
  output logic                       char_ready,
  input  logic [7:0]                 char_data,
  input  logic [3:0]                 fg_color,
  input  logic [3:0]                 bg_color,
  output logic                       wr_en,
  output logic [DP_X_ADDR_WIDTH-1:0] wr_x,
  output logic [DP_Y_ADDR_WIDTH-1:0] wr_y,
  output logic [15:0]                wr_data,
  output logic [DP_X_ADDR_WIDTH-1:0] rd_x,
  output logic [DP_Y_ADDR_WIDTH-1:0] rd_y,
  input  logic [15:0]                rd_data,
  output logic [DP_REG_WIDTH-1:0]    ctrl_reg,
  output logic                       busy
);

  localparam int XW = DP_X_ADDR_WIDTH;
  localparam int YW = DP_Y_ADDR_WIDTH;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  state_t state, nstate;

  logic [XW-1:0] cx, nx, px, set_px, ld_x, cnt_x;
  logic [YW-1:0] cy, ny, py, set_py, ld_y, ld_end, cnt_y;
  logic [7:0]    ch;
  logic [3:0]    fg, bg;
  logic          set_pend, cnt_load, cnt_step, cnt_done, do_nl;
  logic          is_print;

  console_sweep_counter #(.COLS(COLS)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .start_x (ld_x),
    .start_y (ld_y),
    .end_row (ld_end),
    .step    (cnt_step),
    .x       (cnt_x),
    .y       (cnt_y),
    .done    (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cx    <= '0;
      cy    <= '0;
      px    <= '0;
      py    <= '0;
      ch    <= '0;
      fg    <= '0;
      bg    <= '0;
    end else begin
      state <= nstate;
      cx    <= nx;
      cy    <= ny;
      if (set_pend) begin
        px <= set_px;
        py <= set_py;
      end
      if (char_valid && char_ready) begin
        ch <= char_data;
        fg <= fg_color;
        bg <= bg_color;
      end
    end
  end

  assign is_print = (ch >= ASCII_SP) && (ch != ASCII_DEL);

  always_comb begin
    nstate   = state;
    nx       = cx;
    ny       = cy;
    wr_en    = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_data  = '0;
    rd_x     = '0;
    rd_y     = '0;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    ld_x     = '0;
    ld_y     = '0;
    ld_end   = '0;
    set_pend = 1'b0;
    set_px   = '0;
    set_py   = '0;
    do_nl    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (char_valid && char_ready) nstate = ST_EXEC;
      end
      ST_EXEC: begin
        nstate = ST_IDLE;
        unique case (1'b1)
          is_print: begin
            wr_en   = 1'b1;
            wr_x    = cx;
            wr_y    = cy;
            wr_data = {bg, fg, ch};
            if (cx != X_LAST) nx = cx + 1'b1;
            else              do_nl = 1'b1;
          end
          (ch == ASCII_LF): do_nl = 1'b1;
          (ch == ASCII_CR): nx = '0;
          (ch == ASCII_BS): begin
            if (cx != '0) begin
              nx      = cx - 1'b1;
              wr_en   = 1'b1;
              wr_x    = cx - 1'b1;
              wr_y    = cy;
              wr_data = {bg, fg, ASCII_SP};
            end else if (cy != '0) begin
              nx      = X_LAST;
              ny      = cy - 1'b1;
              wr_en   = 1'b1;
              wr_x    = X_LAST;
              wr_y    = cy - 1'b1;
              wr_data = {bg, fg, ASCII_SP};
            end
          end
          (ch == ASCII_FF): begin
            cnt_load = 1'b1;
            ld_end   = Y_LAST;
            set_pend = 1'b1;
            nstate   = ST_CLR;
          end
          default: ;
        endcase
        if (do_nl) begin
          nx = '0;
          if (cy != Y_LAST) begin
            ny = cy + 1'b1;
          end else begin
            // Cursor holds still until the sweep finishes.
            nx       = cx;
            cnt_load = 1'b1;
            set_pend = 1'b1;
`ifdef CONSOLE_SCROLL_EN
            ld_end   = YW'(ROWS - 2);
            set_py   = Y_LAST;
            nstate   = ST_SC_RD;
`else
            nstate   = ST_CLR;
`endif
          end
        end
      end
      ST_CLR: begin
        wr_en    = 1'b1;
        wr_x     = cnt_x;
        wr_y     = cnt_y;
        wr_data  = {bg, fg, ASCII_SP};
        cnt_step = 1'b1;
        if (cnt_done) begin
          nstate = ST_IDLE;
          nx     = px;
          ny     = py;
        end
      end
`ifdef CONSOLE_SCROLL_EN
      ST_SC_RD: begin
        rd_x   = cnt_x;
        rd_y   = cnt_y + 1'b1;
        nstate = ST_SC_WR;
      end
      ST_SC_WR: begin
        wr_en    = 1'b1;
        wr_x     = cnt_x;
        wr_y     = cnt_y;
        wr_data  = rd_data;
        cnt_step = 1'b1;
        nstate   = ST_SC_RD;
        if (cnt_done) begin
          cnt_load = 1'b1;
          ld_y     = Y_LAST;
          ld_end   = Y_LAST;
          nstate   = ST_CLR;
        end
      end
`endif
      default: nstate = ST_IDLE;
    endcase
  end

`ifndef CONSOLE_SCROLL_EN
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  assign char_ready = (state == ST_IDLE) && reset_n;
  assign busy = (state == ST_CLR) || (state == ST_SC_RD) ||
                (state == ST_SC_WR);

  always_comb begin
    ctrl_reg = '0;
    ctrl_reg[CUR_X_MSB:CUR_X_LSB] = 8'(cx);
    ctrl_reg[CUR_Y_MSB:CUR_Y_LSB] = cy;
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer with a buffer model.
module tb_text_console_writer;
  import text_console_writer_pkg::*;

  logic        clk = 0;
  logic        reset_n = 1;
  logic        char_valid = 0;
  logic        char_ready;
  logic [7:0]  char_data = 0;
  logic [3:0]  fg_color = 0, bg_color = 0;
  logic        wr_en;
  logic [DP_X_ADDR_WIDTH-1:0] wr_x, rd_x;
  logic [DP_Y_ADDR_WIDTH-1:0] wr_y, rd_y;
  logic [15:0] wr_data;
  logic [15:0] rd_data = 0;
  logic [DP_REG_WIDTH-1:0] ctrl_reg;
  logic        busy;

  logic [15:0] mem [0:29][0:79];
  int tests = 0, failed = 0, writes = 0, viol = 0;
  int bc, w0, bad;

  text_console_writer dut (
    .clk(clk), .reset_n(reset_n), .char_valid(char_valid),
    .char_ready(char_ready), .char_data(char_data),
    .fg_color(fg_color), .bg_color(bg_color), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x),
    .rd_y(rd_y), .rd_data(rd_data), .ctrl_reg(ctrl_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_x < 80 && rd_y < 30) rd_data <= mem[rd_y][rd_x];
    if (wr_en === 1'b1) begin
      writes++;
      if (wr_x < 80 && wr_y < 30) mem[wr_y][wr_x] = wr_data;
    end
  end

  always @(negedge clk)
    if (busy === 1'b1 && char_ready !== 1'b0) viol++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [3:0] f,
                      input logic [3:0] g);
    int n = 0;
    while (char_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) begin
      tests++;
      failed++;
      $error("FAIL send_timeout: observed busy expected ready");
    end
    char_valid = 1;
    char_data  = b;
    fg_color   = f;
    bg_color   = g;
    @(negedge clk);
    char_valid = 0;
    char_data  = 8'h00;
  endtask

  task automatic settle(output int bcyc);
    int n = 0;
    bcyc = 0;
    while (char_ready !== 1'b1 && n < 10000) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      n++;
    end
    if (n >= 10000) begin
      tests++;
      failed++;
      $error("FAIL settle_timeout: observed busy expected ready");
    end
  endtask

  initial begin
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) mem[r][c] = 16'hFFFF;

    reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrl", ctrl_reg, 32'h0);
    chk("rst_wr_xy", {wr_x, wr_y}, 32'h0);
    chk("rst_rd_xy", {rd_x, rd_y}, 32'h0);
    reset_n = 1;
    #1;
    chk("post_rst_ready", 32'(char_ready), 32'd1);

    w0 = writes;
    send(8'h41, 4'hF, 4'h1);
    chk("A_wr_en_n1", 32'(wr_en), 32'd1);
    chk("A_wr_data", 32'(wr_data), 32'h1F41);
    chk("A_wr_xy", {wr_x, wr_y}, 32'h0);
    @(negedge clk);
    chk("A_ready_n2", 32'(char_ready), 32'd1);
    chk("A_ctrl", 32'(ctrl_reg[12:0]), 32'h0001);
    chk("A_writes", writes - w0, 1);

    send(ASCII_CR, 4'h0, 4'h0); settle(bc);
    for (int i = 0; i < 3; i++) begin send(ASCII_LF, 4'h0, 4'h0); settle(bc); end
    for (int i = 0; i < 79; i++) begin send(8'h78, 4'h7, 4'h0); settle(bc); end
    chk("pos_79_3", ctrl_reg, 32'h034F);
    w0 = writes;
    send(8'h5A, 4'h2, 4'h3); settle(bc);
    chk("Z_cell", 32'(mem[3][79]), 32'h325A);
    chk("Z_ctrl", ctrl_reg, 32'h0400);
    send(ASCII_BS, 4'h2, 4'h3); settle(bc);
    chk("BS_wrap_cell", 32'(mem[3][79]), 32'h3220);
    chk("BS_wrap_ctrl", ctrl_reg, 32'h034F);
    chk("Z_BS_writes", writes - w0, 2);

    w0 = writes;
    viol = 0;
    send(ASCII_FF, 4'h7, 4'h2); settle(bc);
    chk("FF_writes", writes - w0, 2400);
    chk("FF_busy_cycles", bc, 2400);
    chk("FF_ready_low", viol, 0);
    chk("FF_ctrl", ctrl_reg, 32'h0);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) if (mem[r][c] !== 16'h2720) bad++;
    chk("FF_cells", bad, 0);

    w0 = writes;
    send(ASCII_BS, 4'h1, 4'h1); settle(bc);
    chk("BS_home_writes", writes - w0, 0);
    chk("BS_home_ctrl", ctrl_reg, 32'h0);

    send(8'h68, 4'h1, 4'h0); settle(bc);
    send(8'h65, 4'h1, 4'h0); settle(bc);
    send(8'h6C, 4'h1, 4'h0); settle(bc);
    send(8'h6C, 4'h1, 4'h0); settle(bc);
    send(8'hE9, 4'h1, 4'h0); settle(bc);
    chk("hi_cell", 32'(mem[0][4]), 32'h01E9);
    chk("hi_ctrl", ctrl_reg, 32'h0005);
    w0 = writes;
    send(8'h01, 4'h1, 4'h0); settle(bc);
    send(ASCII_DEL, 4'h1, 4'h0); settle(bc);
    chk("ign_ctrl", ctrl_reg, 32'h0005);
    send(ASCII_CR, 4'h1, 4'h0); settle(bc);
    send(ASCII_LF, 4'h1, 4'h0); settle(bc);
    chk("crlf_writes", writes - w0, 0);
    chk("crlf_ctrl", ctrl_reg, 32'h0100);

    for (int i = 0; i < 28; i++) begin send(ASCII_LF, 4'h0, 4'h0); settle(bc); end
    for (int i = 0; i < 10; i++) begin send(8'h71, 4'h0, 4'h0); settle(bc); end
    chk("pos_10_29", ctrl_reg, 32'h1D0A);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) mem[r][c] = {8'(r), 8'(c)};

    w0 = writes;
    viol = 0;
    send(ASCII_LF, 4'h4, 4'h5); settle(bc);
    chk("bot_ready_low", viol, 0);
    bad = 0;
`ifdef CONSOLE_SCROLL_EN
    chk("scroll_busy", bc, 4720);
    chk("scroll_writes", writes - w0, 2400);
    chk("scroll_ctrl", ctrl_reg, 32'h1D00);
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 80; c++)
        if (mem[r][c] !== {8'(r + 1), 8'(c)}) bad++;
    for (int c = 0; c < 80; c++) if (mem[29][c] !== 16'h5420) bad++;
    chk("scroll_cells", bad, 0);
`else
    chk("wrap_busy", bc, 80);
    chk("wrap_writes", writes - w0, 80);
    chk("wrap_ctrl", ctrl_reg, 32'h0);
    for (int c = 0; c < 80; c++) if (mem[0][c] !== 16'h5420) bad++;
    for (int r = 1; r < 30; r++)
      for (int c = 0; c < 80; c++)
        if (mem[r][c] !== {8'(r), 8'(c)}) bad++;
    chk("wrap_cells", bad, 0);
    for (int i = 0; i < 29; i++) begin send(ASCII_LF, 4'h0, 4'h0); settle(bc); end
`endif

    send(ASCII_LF, 4'h4, 4'h5);
    repeat (40) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 0;
    @(negedge clk);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_ctrl", ctrl_reg, 32'h0);
    w0 = writes;
    repeat (3) @(negedge clk);
    chk("abort_no_writes", writes - w0, 0);
    reset_n = 1;
    #1;
    chk("abort_ready", 32'(char_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the text display path: accepts ASCII bytes over a valid/ready handshake and writes `{bg, fg, ascii}` cells into the 80×30 text buffer at the current cursor position. The display controller scans the same buffer. Interprets the control codes CR, LF, BS and FF, wraps at the line end, and handles the bottom-of-screen case by scrolling or by wrapping to row 0. Drives the cursor fields of the display control register, so the blinking cursor tracks the write position.

## Interface
- `COLS`, 80: text columns; column index range is 0..COLS-1.
- `ROWS`, 30: text rows; row index range is 0..ROWS-1.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `char_valid` in 1: `char_data` is valid.
- `char_ready` out 1: the block accepts a byte this cycle.
- `char_data` in 8: ASCII byte.
- `fg_color` in 4: foreground colour. Sampled together with the byte.
- `bg_color` in 4: background colour. Sampled together with the byte.
- `wr_en` out 1: text buffer write strobe.
- `wr_x` out `DP_X_ADDR_WIDTH`: write column.
- `wr_y` out `DP_Y_ADDR_WIDTH`: write row.
- `wr_data` out 16: cell word `{bg[3:0], fg[3:0], ascii[7:0]}`.
- `rd_x` out `DP_X_ADDR_WIDTH`: buffer read column (scroll only).
- `rd_y` out `DP_Y_ADDR_WIDTH`: buffer read row (scroll only).
- `rd_data` in 16: read data, valid one cycle after the address is presented.
- `ctrl_reg` out `DP_REG_WIDTH`: `[7:0]` holds cursor x, `[12:8]` holds cursor y, all other bits are 0.
- `busy` out 1: a multi-cycle sweep (scroll or clear) is in progress.

## Operation
- States:
  - IDLE: `char_ready`=1; waiting for a byte.
  - EXEC: one cycle; acts on the byte latched in IDLE.
  - CLR: clear sweep.
  - SC_RD: scroll sweep, read phase.
  - SC_WR: scroll sweep, write phase.
- Acceptance: a byte is accepted on `char_valid && char_ready`. The byte and both colours are latched, and the FSM moves to EXEC.
- Printable bytes (0x20–0x7E and 0x80–0xFF) in EXEC:
  - Write the cell at (x, y).
  - If x < COLS-1, x increments.
  - If x = COLS-1, the block performs a NEWLINE.
- 0x0A LF: NEWLINE.
- 0x0D CR: x=0.
- 0x08 BS:
  - If x>0: x decrements, then a space (0x20, latched colours) is written at the new x.
  - If x=0 and y>0: x=COLS-1, y decrements, and a space is written there.
  - At (0,0): no operation.
- 0x0C FF: clear the whole screen to spaces in the latched colours, then set the cursor to (0,0).
- Other bytes below 0x20 and 0x7F: consumed without effect.
- NEWLINE: x=0.
  - If y < ROWS-1: y increments.
  - Otherwise: bottom-of-screen handling (see Configuration).
- CLR: walks a cell range row-major at 1 cell/cycle, writing spaces. `busy`=1.
- Scroll sweep: for each destination cell (x, y) with y = 0..ROWS-2:
  - SC_RD presents (x, y+1) on `rd_x`/`rd_y`.
  - SC_WR writes `rd_data` to (x, y).
  - After the sweep, CLR clears row ROWS-1.
- Cursor (`ctrl_reg`) reset value is (0,0). It is updated at the end of EXEC, or at the end of the sweep for FF and scroll.

## Timing
- Reset values:
  - `char_ready`=0 during reset, 1 in the first cycle after reset.
  - `wr_en`=0, `busy`=0, `ctrl_reg`=0.
  - `wr_*` and `rd_*` addresses are 0.
- Buffer contents are not touched by reset.
- Simple bytes (printable, CR, LF or BS without scroll): accepted in cycle N, `wr_en` pulses in cycle N+1, cursor is updated at the edge ending N+1, `char_ready` returns in N+2. Peak throughput is 1 byte per 2 cycles.
- Full clear: COLS·ROWS = 2400 write cycles.
- Scroll: 2·COLS·(ROWS-1) = 4640 cycles, plus COLS = 80 clear cycles.
- `char_ready`=0 for the whole of any sweep.
- `wr_en` is high for exactly one cycle per cell written. `rd_*` is don't-care outside SC_RD.
- `reset_n`=0 mid-sweep: the sweep aborts at that edge and no further writes are issued. A partially scrolled screen is acceptable.
- `char_valid` deasserted while `char_ready`=0 has no effect. Data need not be held stable while not ready.

## Configuration
- `CONSOLE_SCROLL_EN` defined: NEWLINE on row ROWS-1 runs the scroll sweep and the cursor stays at (0, ROWS-1).
- `CONSOLE_SCROLL_EN` undefined: NEWLINE on row ROWS-1 sets the cursor to (0,0) and runs CLR on row 0 only (80 cycles).
  - SC_RD and SC_WR are not built.
  - `rd_x`/`rd_y` are tied to 0.

## Structure
- Shared package (with the existing display widths and register layout) holds:
  - `DP_X_ADDR_WIDTH`, `DP_Y_ADDR_WIDTH`, `DP_REG_WIDTH`.
  - Cursor field positions within `ctrl_reg`.
  - Control-code constants `ASCII_BS`, `ASCII_LF`, `ASCII_FF`, `ASCII_CR`.
  - The state encoding.
- Sub-module `console_sweep_counter` is a row-major (x, y) walker with a start position, an end row, a step enable and a `done` flag. CLR and the scroll sweep share it.

## Test plan
- Reset, then send 'A' with fg=0xF, bg=0x1 → one write of 0x1F41 at (0,0), then `ctrl_reg`[12:0]=0x0001.
- Cursor at (79,3), send 'Z' → write at (79,3), then cursor (0,4). Then send BS → a space is written at (79,3) and the cursor returns to (79,3).
- Cursor at (5,0), send CR then LF → no writes, cursor (0,1). BS at (0,0) → no write, cursor unchanged.
- Send FF with bg=0x2 → exactly 2400 `wr_en` pulses of data 0x2?20 across (0,0)..(79,29). `busy` is high throughout and `char_ready` is low. Cursor ends at (0,0).
- With `CONSOLE_SCROLL_EN`, cursor at (10,29), send LF:
  - Each row r≥1 is copied to row r-1, row 29 is filled with spaces.
  - Cursor ends at (0,29), after 4720 busy cycles.
  - Without the macro: row 0 is cleared, cursor ends at (0,0), after 80 busy cycles.
- Assert `reset_n`=0 mid-scroll → next cycle `wr_en`=0 and `ctrl_reg`=0. After release, `char_ready`=1.
